// File: rtl/data_memory_pipelined.sv
// data_memory_pipelined: byte-addressed data-side memory for the LSU using the
// req/gnt/rvalid handshake. Grant latency and response latency are programmable.
// Up to MAX_OUTSTANDING granted requests can be in flight, and responses return
// in order at a rate of at most one per cycle.
// Optional feature macro: DMEM_RANGE_CHECK_EN. When it is defined, a word index
// >= NUM_WORDS is still granted, but the write is dropped and the response
// carries err_o=1 with rdata_o=0. When it is undefined, the index wraps modulo
// NUM_WORDS and err_o is always 0.
//
// Grant FSM
//   state | meaning
//   IDLE  | no ungranted request carried over from the previous cycle
//   WAITG | req_i was high last cycle without a grant; wait_cnt is counting
module data_memory_pipelined #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_WORDS       = 256,
    parameter int GRANT_LAT       = 1,
    parameter int RESP_LAT        = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    gnt_o,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    err_o
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int OFF = $clog2(NB);
    localparam int IW  = ADDR_WIDTH - OFF;
    localparam int MW  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int WCW = (GRANT_LAT > 0) ? $clog2(GRANT_LAT + 1) : 1;
    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int NST = (RESP_LAT > 1) ? RESP_LAT - 1 : 1;
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(GRANT_LAT);
    localparam logic [OW-1:0]  OUT_MAX  = OW'(MAX_OUTSTANDING);

    typedef enum logic {IDLE, WAITG} gstate_t;

    gstate_t               state;
    logic [WCW-1:0]        wait_cnt;
    logic [OW-1:0]         outstanding;
    logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

    logic [IW-1:0]         word_full;
    logic [MW-1:0]         word_idx;
    logic                  in_range;
    logic                  wait_ok;
    logic                  slot_ok;
    logic                  accept;
    logic [DATA_WIDTH-1:0] new_rdata;
    logic                  new_err;

    // All responses share the same fixed latency and at most one is accepted
    // per cycle, so the countdown queue reduces to a delay line. The entry at
    // the last stage is the one whose countdown has expired.
    logic [NST-1:0]        pv;
    logic [NST-1:0]        pe;
    logic [DATA_WIDTH-1:0] pd [NST];
    logic                  pop_valid;
    logic                  pop_err;
    logic [DATA_WIDTH-1:0] pop_rdata;
    logic                  pipe_pop;

    logic unused_addr;
    assign unused_addr = ^addr_i[OFF-1:0];

    assign word_full = addr_i[ADDR_WIDTH-1:OFF];
    assign word_idx  = MW'(word_full % IW'(NUM_WORDS));

`ifdef DMEM_RANGE_CHECK_EN
    assign in_range = (word_full < IW'(NUM_WORDS));
`else
    assign in_range = 1'b1;
`endif

    assign wait_ok   = (GRANT_LAT == 0) || ((state == WAITG) && (wait_cnt == WAIT_MAX));
    // A pop on this edge frees its slot in time for a same-cycle grant.
    assign slot_ok   = (outstanding < OUT_MAX) || pipe_pop;
    assign gnt_o     = !rst && req_i && wait_ok && slot_ok;
    assign accept    = req_i && gnt_o;
    assign new_rdata = (we_i || !in_range) ? '0 : mem[word_idx];
    assign new_err   = !in_range;

    generate
        if (RESP_LAT == 1) begin : g_bypass
            assign pop_valid = accept;
            assign pop_rdata = new_rdata;
            assign pop_err   = new_err;
            assign pipe_pop  = 1'b0;
        end else begin : g_pipe
            assign pop_valid = pv[NST-1];
            assign pop_rdata = pd[NST-1];
            assign pop_err   = pe[NST-1];
            assign pipe_pop  = pv[NST-1];
        end
    endgenerate

    // Grant FSM: count ungranted request cycles and clear on accept or idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else if (!req_i || accept) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state <= WAITG;
            if (wait_cnt != WAIT_MAX)
                wait_cnt <= wait_cnt + WCW'(1);
        end
    end

    // Outstanding request count: +1 on accept, -1 on pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            outstanding <= '0;
        else if (accept && !pop_valid)
            outstanding <= outstanding + OW'(1);
        else if (!accept && pop_valid)
            outstanding <= outstanding - OW'(1);
    end

    // Memory array: byte-lane writes commit on the accept edge and are not reset.
    always_ff @(posedge clk) begin
        if (accept && we_i && in_range) begin
            for (int i = 0; i < NB; i++)
                if (be_i[i])
                    mem[word_idx][8*i +: 8] <= wdata_i[8*i +: 8];
        end
    end

    // Response delay line: stage 0 captures the accepted entry and later stages shift it along.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv <= '0;
            pe <= '0;
            for (int k = 0; k < NST; k++)
                pd[k] <= '0;
        end else begin
            pv[0] <= accept;
            pe[0] <= new_err;
            pd[0] <= new_rdata;
            for (int k = 1; k < NST; k++) begin
                pv[k] <= pv[k-1];
                pe[k] <= pe[k-1];
                pd[k] <= pd[k-1];
            end
        end
    end

    // Registered response outputs: data and err hold their values between responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
            err_o    <= 1'b0;
        end else begin
            rvalid_o <= pop_valid;
            if (pop_valid) begin
                rdata_o <= pop_rdata;
                err_o   <= pop_err;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_pipelined.sv
// Testbench for data_memory_pipelined. It uses two instances:
//   a: default parameters (GRANT_LAT=1, RESP_LAT=2, MAX_OUTSTANDING=4)
//   b: GRANT_LAT=0, RESP_LAT=4, MAX_OUTSTANDING=2
// Expected responses are pushed to a queue on each accept and compared on each rvalid.
module tb_data_memory_pipelined;
    localparam int RL_A = 2;
    localparam int RL_B = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, req_a, we_a, gnt_a, rvalid_a, err_a;
    logic [31:0] addr_a, wdata_a, rdata_a;
    logic [3:0]  be_a;
    logic        rst_b, req_b, we_b, gnt_b, rvalid_b, err_b;
    logic [31:0] addr_b, wdata_b, rdata_b;
    logic [3:0]  be_b;

    data_memory_pipelined dut_a (
        .clk(clk), .rst(rst_a), .req_i(req_a), .addr_i(addr_a), .we_i(we_a),
        .be_i(be_a), .wdata_i(wdata_a), .gnt_o(gnt_a), .rvalid_o(rvalid_a),
        .rdata_o(rdata_a), .err_o(err_a)
    );

    data_memory_pipelined #(.GRANT_LAT(0), .RESP_LAT(RL_B), .MAX_OUTSTANDING(2)) dut_b (
        .clk(clk), .rst(rst_b), .req_i(req_b), .addr_i(addr_b), .we_i(we_b),
        .be_i(be_b), .wdata_i(wdata_b), .gnt_o(gnt_b), .rvalid_o(rvalid_b),
        .rdata_o(rdata_b), .err_o(err_b)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    logic        last_gnt_a, last_gnt_b, last_acc_a, last_acc_b;
    logic [31:0] last_rdata_a, last_rdata_b;
    logic        last_err_a, last_err_b;

    // Reference model: compute the expected response and update the model memory.
    task automatic model_accept(input bit is_b, input logic [31:0] addr, input logic we,
                                input logic [3:0] be, input logic [31:0] wd);
        int          wfull;
        int          idx;
        logic        in_rng;
        logic [31:0] w;
        exp_t        e;
        wfull  = int'(addr[31:2]);
        in_rng = 1'b1;
`ifdef DMEM_RANGE_CHECK_EN
        in_rng = (wfull < 256);
`endif
        idx = wfull % 256;
        if (is_b) w = mem_b[idx];
        else      w = mem_a[idx];
        e.err  = !in_rng;
        e.data = (we || !in_rng) ? 32'h0 : w;
        e.due  = cyc + (is_b ? RL_B : RL_A);
        if (we && in_rng) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
            if (is_b) mem_b[idx] = w;
            else      mem_a[idx] = w;
        end
        if (is_b) q_b.push_back(e);
        else      q_a.push_back(e);
    endtask

    task automatic check_resp(input bit is_b);
        logic        rv, er;
        logic [31:0] rd;
        int          qs;
        exp_t        e;
        string       nm;
        nm = is_b ? "b" : "a";
        rv = is_b ? rvalid_b : rvalid_a;
        rd = is_b ? rdata_b  : rdata_a;
        er = is_b ? err_b    : err_a;
        qs = is_b ? q_b.size() : q_a.size();
        if (rv) begin
            if (is_b) begin last_rdata_b = rd; last_err_b = er; end
            else      begin last_rdata_a = rd; last_err_a = er; end
            tests++;
            if (qs == 0) begin
                fails++;
                $display("FAIL resp_%s_unexpected cyc=%0d got rdata=%h err=%b, expected no response", nm, cyc, rd, er);
            end else begin
                if (is_b) e = q_b.pop_front();
                else      e = q_a.pop_front();
                if (rd !== e.data) begin
                    fails++;
                    $display("FAIL resp_%s_rdata cyc=%0d got %h expected %h", nm, cyc, rd, e.data);
                end
                tests++;
                if (er !== e.err) begin
                    fails++;
                    $display("FAIL resp_%s_err cyc=%0d got %b expected %b", nm, cyc, er, e.err);
                end
                tests++;
                if (cyc != e.due) begin
                    fails++;
                    $display("FAIL resp_%s_latency got cycle %0d expected cycle %0d", nm, cyc, e.due);
                end
            end
        end else if (qs > 0) begin
            if (is_b) e = q_b[0];
            else      e = q_a[0];
            if (e.due <= cyc) begin
                tests++;
                fails++;
                $display("FAIL resp_%s_missing cyc=%0d expected rdata=%h at cycle %0d", nm, cyc, e.data, e.due);
                if (is_b) void'(q_b.pop_front());
                else      void'(q_a.pop_front());
            end
        end
    endtask

    // One clock cycle: sample grants before the edge, then check responses after it.
    task automatic step();
        #1;
        last_gnt_a = gnt_a;
        last_gnt_b = gnt_b;
        last_acc_a = req_a && gnt_a;
        last_acc_b = req_b && gnt_b;
        if (last_acc_a) model_accept(1'b0, addr_a, we_a, be_a, wdata_a);
        if (last_acc_b) model_accept(1'b1, addr_b, we_b, be_b, wdata_b);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_resp(1'b0);
        check_resp(1'b1);
    endtask

    task automatic req_a_op(input logic [31:0] addr, input logic we, input logic [3:0] be,
                            input logic [31:0] wd, output int waited);
        req_a = 1'b1; addr_a = addr; we_a = we; be_a = be; wdata_a = wd;
        waited = 0;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (last_acc_a) begin waited = n; break; end
        end
        req_a = 1'b0; we_a = 1'b0; be_a = 4'h0;
        if (waited == 0) begin
            tests++; fails++;
            $display("FAIL grant_timeout_a addr=%h got no grant within 20 cycles", addr);
        end
    endtask

    task automatic req_b_op(input logic [31:0] addr, input logic we, input logic [3:0] be,
                            input logic [31:0] wd, output int waited);
        req_b = 1'b1; addr_b = addr; we_b = we; be_b = be; wdata_b = wd;
        waited = 0;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (last_acc_b) begin waited = n; break; end
        end
        req_b = 1'b0; we_b = 1'b0; be_b = 4'h0;
        if (waited == 0) begin
            tests++; fails++;
            $display("FAIL grant_timeout_b addr=%h got no grant within 20 cycles", addr);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q_a.size() > 0 || q_b.size() > 0) && n < 20) begin
            step();
            n++;
        end
        if (q_a.size() > 0 || q_b.size() > 0) begin
            tests++; fails++;
            $display("FAIL drain_timeout pending a=%0d b=%0d expected 0", q_a.size(), q_b.size());
            q_a.delete();
            q_b.delete();
        end
        step();
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1; req_a = 1'b1; req_b = 1'b1;
        step();
        tests++;
        if (last_gnt_a !== 1'b0) begin fails++; $display("FAIL reset_gnt_a got %b expected 0", last_gnt_a); end
        tests++;
        if (last_gnt_b !== 1'b0) begin fails++; $display("FAIL reset_gnt_b got %b expected 0", last_gnt_b); end
        req_a = 1'b0; req_b = 1'b0;
        step();
        rst_a = 1'b0; rst_b = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            tests++;
            if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0) begin
                fails++; $display("FAIL idle_rvalid got a=%b b=%b expected 0", rvalid_a, rvalid_b);
            end
            tests++;
            if (last_gnt_a !== 1'b0 || last_gnt_b !== 1'b0) begin
                fails++; $display("FAIL idle_gnt got a=%b b=%b expected 0", last_gnt_a, last_gnt_b);
            end
            tests++;
            if (err_a !== 1'b0 || err_b !== 1'b0) begin
                fails++; $display("FAIL idle_err got a=%b b=%b expected 0", err_a, err_b);
            end
            tests++;
            if (rdata_a !== 32'h0) begin
                fails++; $display("FAIL idle_rdata_a got %h expected 0", rdata_a);
            end
        end
    endtask

    task automatic test_write_read();
        int w;
        req_a_op(32'h10, 1'b1, 4'hF, 32'hDEADBEEF, w);
        tests++;
        if (w != 2) begin fails++; $display("FAIL wr_grant_cycle got %0d expected 2", w); end
        req_a_op(32'h10, 1'b0, 4'h0, 32'h0, w);
        tests++;
        if (w != 2) begin fails++; $display("FAIL rd_grant_cycle got %0d expected 2", w); end
        drain();
        tests++;
        if (last_rdata_a !== 32'hDEADBEEF) begin
            fails++; $display("FAIL rd_data_0x10 got %h expected deadbeef", last_rdata_a);
        end
    endtask

    task automatic test_byte_enables();
        int w;
        req_a_op(32'h20, 1'b1, 4'hF, 32'h11223344, w);
        req_a_op(32'h20, 1'b1, 4'b0101, 32'hAABBCCDD, w);
        req_a_op(32'h20, 1'b0, 4'h0, 32'h0, w);
        drain();
        tests++;
        if (last_rdata_a !== 32'h11BB33DD) begin
            fails++; $display("FAIL be_merge got %h expected 11bb33dd", last_rdata_a);
        end
        req_a_op(32'h20, 1'b1, 4'h0, 32'hFFFFFFFF, w);
        req_a_op(32'h20, 1'b0, 4'h0, 32'h0, w);
        drain();
        tests++;
        if (last_rdata_a !== 32'h11BB33DD) begin
            fails++; $display("FAIL be_zero got %h expected 11bb33dd", last_rdata_a);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        int n = 0;
        int rel = 0;
        int gcyc[4];
        int exp_g[4] = '{0, 1, 3, 4};
        for (int i = 0; i < 4; i++)
            req_b_op(32'h40 + 32'(i * 4), 1'b1, 4'hF, 32'h10000000 + 32'(i * 32'h111), w);
        drain();
        req_b = 1'b1; we_b = 1'b0; be_b = 4'h0;
        while (n < 4 && rel < 40) begin
            addr_b = 32'h40 + 32'(n * 4);
            step();
            if (last_acc_b) begin gcyc[n] = rel; n++; end
            rel++;
        end
        req_b = 1'b0;
        tests++;
        if (n != 4) begin fails++; $display("FAIL b2b_grant_count got %0d expected 4", n); end
        for (int i = 0; i < n; i++) begin
            tests++;
            if (gcyc[i] != exp_g[i]) begin
                fails++; $display("FAIL b2b_grant_cycle[%0d] got %0d expected %0d", i, gcyc[i], exp_g[i]);
            end
        end
        drain();
        tests++;
        if (last_rdata_b !== 32'h10000333) begin
            fails++; $display("FAIL b2b_last_data got %h expected 10000333", last_rdata_b);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        req_b_op(32'h40, 1'b0, 4'h0, 32'h0, w);
        req_b_op(32'h44, 1'b0, 4'h0, 32'h0, w);
        rst_b = 1'b1;
        q_b.delete();
        step();
        step();
        rst_b = 1'b0;
        tests++;
        if (rdata_b !== 32'h0) begin fails++; $display("FAIL rst_mid_rdata got %h expected 0", rdata_b); end
        for (int i = 0; i < 8; i++) begin
            step();
            tests++;
            if (rvalid_b !== 1'b0) begin fails++; $display("FAIL rst_mid_rvalid cycle %0d got 1 expected 0", i); end
        end
        req_b_op(32'h48, 1'b0, 4'h0, 32'h0, w);
        drain();
        tests++;
        if (last_rdata_b !== 32'h10000222) begin
            fails++; $display("FAIL rst_mid_read got %h expected 10000222", last_rdata_b);
        end
    endtask

    task automatic test_range();
        int w;
        req_a_op(32'h0, 1'b1, 4'hF, 32'h5A5A1234, w);
        req_a_op(32'h400, 1'b1, 4'hF, 32'hCAFEF00D, w);
        req_a_op(32'h400, 1'b0, 4'h0, 32'h0, w);
        drain();
`ifdef DMEM_RANGE_CHECK_EN
        tests++;
        if (last_err_a !== 1'b1 || last_rdata_a !== 32'h0) begin
            fails++; $display("FAIL range_oob_read got err=%b rdata=%h expected err=1 rdata=0", last_err_a, last_rdata_a);
        end
`else
        tests++;
        if (last_err_a !== 1'b0 || last_rdata_a !== 32'hCAFEF00D) begin
            fails++; $display("FAIL range_wrap_read got err=%b rdata=%h expected err=0 rdata=cafef00d", last_err_a, last_rdata_a);
        end
`endif
        req_a_op(32'h0, 1'b0, 4'h0, 32'h0, w);
        drain();
        tests++;
`ifdef DMEM_RANGE_CHECK_EN
        if (last_rdata_a !== 32'h5A5A1234) begin
            fails++; $display("FAIL range_word0 got %h expected 5a5a1234", last_rdata_a);
        end
`else
        if (last_rdata_a !== 32'hCAFEF00D) begin
            fails++; $display("FAIL range_word0 got %h expected cafef00d", last_rdata_a);
        end
`endif
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        req_a = 1'b0; we_a = 1'b0; be_a = 4'h0; addr_a = 32'h0; wdata_a = 32'h0;
        req_b = 1'b0; we_b = 1'b0; be_b = 4'h0; addr_b = 32'h0; wdata_b = 32'h0;
        last_rdata_a = 32'h0; last_rdata_b = 32'h0; last_err_a = 1'b0; last_err_b = 1'b0;
        for (int i = 0; i < 256; i++) begin mem_a[i] = 32'h0; mem_b[i] = 32'h0; end
        @(negedge clk);
        test_reset();
        test_write_read();
        test_byte_enables();
        test_back_to_back();
        test_reset_mid();
        test_range();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
